mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 10 +
 rtl/rr_arb2.sv | 37 +++
 rtl/mem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizes for the I/D memory arbiter.
package mem_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {CLI_I = 1'b0, CLI_D = 1'b1} client_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the client not granted last wins.
// Bit 0 of req/mask is the I client and bit 1 is the D client.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic       gnt_vld,
  output logic       gnt_d
);

  logic       last_d;
  logic [1:0] eff;

  always_comb begin
    eff     = req & ~mask;
    gnt_vld = en && (eff != 2'b00);
    if (eff == 2'b11) begin
      gnt_d = !last_d;
    end else begin
      gnt_d = eff[1];
    end
  end

  // Last grant starts at I so that D wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (gnt_vld) begin
      last_d <= gnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and the D-cache.
// A flush cancels the I-side response but lets the memory access run to completion.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              reqI,
  input  logic [ADDR_W-1:0] addrI,
  input  logic              reqD,
  input  logic              weD,
  input  logic [ADDR_W-1:0] addrD,
  input  logic [LINE_W-1:0] wdataD,
  output logic [LINE_W-1:0] rdata,
  output logic              readyI,
  output logic              readyD,
  output logic              ackD,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  state_t     state, state_nxt;
  client_t    cli, gnt, mask_cli;
  logic       gnt_vld, gnt_d;
  logic       cancel;
  logic       mask_vld;
  logic [1:0] mask;

  // The client just served is still holding its request for one IDLE cycle.
  assign mask = {mask_vld && (mask_cli == CLI_D), mask_vld && (mask_cli == CLI_I)};
  assign gnt  = gnt_d ? CLI_D : CLI_I;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .en      (state == IDLE),
    .req     ({reqD, reqI}),
    .mask    (mask),
    .gnt_vld (gnt_vld),
    .gnt_d   (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == BUSY);
    readyI  = (state == RESP) && (cli == CLI_I) && !cancel;
    readyD  = (state == RESP) && (cli == CLI_D) && !mem_we;
    ackD    = (state == RESP) && (cli == CLI_D) && mem_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cli       <= CLI_I;
      cancel    <= 1'b0;
      mask_vld  <= 1'b0;
      mask_cli  <= CLI_I;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      mask_vld <= (state == RESP);
      mask_cli <= cli;
      if (state == IDLE && gnt_vld) begin
        cli       <= gnt;
        mem_we    <= (gnt == CLI_D) && weD;
        mem_addr  <= (gnt == CLI_D) ? addrD : addrI;
        mem_wdata <= (gnt == CLI_D) ? wdataD : '0;
        cancel    <= flush && (gnt == CLI_I);
      end else if (state == BUSY && flush && cli == CLI_I) begin
        cancel <= 1'b1;
      end
      // Writes never disturb the last line returned to a reader.
      if (state == BUSY && mem_ready && !mem_we) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule
